instr_mem_loader: RTL and testbench

//  Writer side of the pipeline processor's 16x8 instruction memory: receives a framed program

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/instr_mem_loader_if.sv | 23 ++
 rtl/instr_mem_loader.sv | 139 +++++++++++++
 tb/tb_instr_mem_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline processor: instruction encoding,
// instruction memory geometry and the program loader state encoding.
package pipe_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   // Opcode values found in instruction bits [7:6]
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   // Instruction field positions
   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 6;
   localparam int RA_MSB  = 3;
   localparam int RA_LSB  = 2;
   localparam int RB_MSB  = 1;
   localparam int RB_LSB  = 0;

   typedef enum logic [2:0] {
      LD_IDLE = 3'd0,
      LD_LEN  = 3'd1,
      LD_DATA = 3'd2,
      LD_CSUM = 3'd3,
      LD_DONE = 3'd4,
      LD_ERR  = 3'd5
   } ld_state_t;

   // True when the instruction carries the undefined opcode
   function automatic logic is_rsvd_op(input logic [DATA_W-1:0] instr);
      return (instr[OPC_MSB:OPC_LSB] == OP_RSVD);
   endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake plus instruction memory write port of the loader.
// slave: the loader side; master: stream source / memory side.
interface instr_mem_loader_if;
   import pipe_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/instr_mem_loader.sv
// Writer side of the instruction memory. Accepts a framed program
// (LEN, N instructions, XOR checksum), writes instructions in arrival order
// and keeps the processor held in reset until a valid program is stored.
module instr_mem_loader
   import pipe_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   instr_mem_loader_if.slave   bus,
   output logic                cpu_hold,
   output logic                load_done,
   output logic                load_err,
   output logic [ADDR_W:0]     prog_len
);

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   ld_state_t         state_r;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W:0]   len_r;
   logic [DATA_W-1:0] csum_r;
   logic              in_ready_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              cpu_hold_r;
   logic              load_done_r;
   logic              load_err_r;
   logic [ADDR_W:0]   prog_len_r;

   logic              xfer_s;
   logic [ADDR_W:0]   count_nxt_s;

   assign xfer_s      = bus.in_valid & in_ready_r;
   assign count_nxt_s = count_r + CNT_ONE;

   // Loader FSM: frame parsing, write generation and status outputs, all registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= LD_IDLE;
         count_r     <= {(ADDR_W+1){1'b0}};
         len_r       <= {(ADDR_W+1){1'b0}};
         csum_r      <= {DATA_W{1'b0}};
         in_ready_r  <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         cpu_hold_r  <= 1'b1;
         load_done_r <= 1'b0;
         load_err_r  <= 1'b0;
         prog_len_r  <= {(ADDR_W+1){1'b0}};
      end else begin
         mem_we_r <= 1'b0;
         case (state_r)
            LD_IDLE: begin
               if (start) begin
                  state_r    <= LD_LEN;
                  in_ready_r <= 1'b1;
               end
            end
            LD_LEN: begin
               if (xfer_s) begin
                  // N is judged on the full byte so e.g. 8'h20 is not mistaken for 0
                  if ((bus.in_data == {DATA_W{1'b0}}) || (bus.in_data > DATA_W'(DEPTH))) begin
                     state_r    <= LD_ERR;
                     in_ready_r <= 1'b0;
                     load_err_r <= 1'b1;
                  end else begin
                     state_r <= LD_DATA;
                     len_r   <= bus.in_data[ADDR_W:0];
                     csum_r  <= bus.in_data;
                     count_r <= {(ADDR_W+1){1'b0}};
                  end
               end
            end
            LD_DATA: begin
               if (xfer_s) begin
                  if (is_rsvd_op(bus.in_data)) begin
                     state_r    <= LD_ERR;
                     in_ready_r <= 1'b0;
                     load_err_r <= 1'b1;
                  end else begin
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= count_r[ADDR_W-1:0];
                     mem_wdata_r <= bus.in_data;
                     csum_r      <= csum_r ^ bus.in_data;
                     count_r     <= count_nxt_s;
                     if (count_nxt_s == len_r) begin
                        state_r <= LD_CSUM;
                     end
                  end
               end
            end
            LD_CSUM: begin
               if (xfer_s) begin
                  in_ready_r <= 1'b0;
                  if (bus.in_data == csum_r) begin
                     state_r     <= LD_DONE;
                     load_done_r <= 1'b1;
                     cpu_hold_r  <= 1'b0;
                     prog_len_r  <= len_r;
                  end else begin
                     state_r    <= LD_ERR;
                     load_err_r <= 1'b1;
                  end
               end
            end
            LD_DONE, LD_ERR: begin
               if (start) begin
                  state_r     <= LD_LEN;
                  in_ready_r  <= 1'b1;
                  cpu_hold_r  <= 1'b1;
                  load_done_r <= 1'b0;
                  load_err_r  <= 1'b0;
                  prog_len_r  <= {(ADDR_W+1){1'b0}};
               end
            end
            default: begin
               state_r     <= LD_IDLE;
               in_ready_r  <= 1'b0;
               cpu_hold_r  <= 1'b1;
               load_done_r <= 1'b0;
               load_err_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign cpu_hold      = cpu_hold_r;
   assign load_done     = load_done_r;
   assign load_err      = load_err_r;
   assign prog_len      = prog_len_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed frames plus randomized
// frames and handshake gaps, compared against a frame-level reference model.
module tb_instr_mem_loader;
   import pipe_pkg::*;

   typedef logic [7:0]  byte_q_t [$];
   typedef logic [11:0] wr_q_t [$];

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            cpu_hold;
   logic            load_done;
   logic            load_err;
   logic [ADDR_W:0] prog_len;

   int    checks = 0;
   int    failures = 0;
   wr_q_t wq;

   instr_mem_loader_if bus();

   instr_mem_loader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bus       (bus.slave),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err),
      .prog_len  (prog_len)
   );

   always #5 clk = ~clk;

   // Write-port monitor and status invariant: processor released exactly when done
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
      checks++;
      if (cpu_hold !== ~load_done) begin
         failures++;
         $display("FAIL hold_vs_done t=%0t cpu_hold=%b load_done=%b required cpu_hold=~load_done",
                  $time, cpu_hold, load_done);
      end
   end

   // Reference model: outcome and write list of a frame, straight from the frame rules
   function automatic void model(input byte_q_t fr, output bit ok, output int plen,
                                 output wr_q_t wexp);
      int n;
      logic [7:0] x;
      logic [7:0] b;
      logic [3:0] a;
      ok = 1'b0; plen = 0; wexp = {};
      n = int'(fr[0]);
      if (n == 0 || n > 16) return;
      x = fr[0];
      for (int i = 0; i < n; i++) begin
         b = fr[1+i];
         if (b[7:6] == 2'b11) return;
         a = 4'(i);
         wexp.push_back({a, b});
         x = x ^ b;
      end
      if (fr[n+1] == x) begin ok = 1'b1; plen = n; end
   endfunction

   // Random frame: kind 0 good, 1 bad checksum, 2 undefined opcode somewhere
   function automatic byte_q_t make_frame(input int n, input int kind);
      byte_q_t f;
      logic [7:0] b;
      logic [7:0] x;
      int bad_pos;
      f = {};
      b = 8'(n);
      f.push_back(b);
      x = b;
      bad_pos = $urandom_range(0, n-1);
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         if (b[7:6] == 2'b11) b[7] = 1'b0;
         if (kind == 2 && i == bad_pos) b[7:6] = 2'b11;
         f.push_back(b);
         x = x ^ b;
      end
      if (kind == 1) x = x ^ 8'h01;
      f.push_back(x);
      return f;
   endfunction

   task automatic send_frame(input byte_q_t fr, input int gap_pct, input bit mid_start);
      int  idx = 0;
      int  cyc = 0;
      logic rdy;
      while (idx < fr.size() && cyc < 400) begin
         @(negedge clk);
         if (load_err === 1'b1 || load_done === 1'b1) break;
         rdy = bus.in_ready;
         start = mid_start && ($urandom_range(0, 5) == 0);
         bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
         bus.in_data  = bus.in_valid ? fr[idx] : 8'($urandom);
         @(posedge clk);
         if (bus.in_valid && rdy) idx++;
         cyc++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic run_and_check(input string name, input byte_q_t fr, input int gap_pct,
                                input bit mid_start);
      bit    ok;
      int    plen;
      wr_q_t wexp;
      @(negedge clk);
      wq.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || cpu_hold !== 1'b1) begin
         failures++;
         $display("FAIL %s_start rdy=%b done=%b err=%b hold=%b required 1,0,0,1",
                  name, bus.in_ready, load_done, load_err, cpu_hold);
      end
      send_frame(fr, gap_pct, mid_start);
      @(negedge clk);
      model(fr, ok, plen, wexp);
      checks++;
      if (load_done !== ok || load_err !== !ok) begin
         failures++;
         $display("FAIL %s_outcome done=%b err=%b required done=%b err=%b",
                  name, load_done, load_err, ok, !ok);
      end
      checks++;
      if (cpu_hold !== !ok || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_hold_rdy hold=%b rdy=%b required hold=%b rdy=0",
                  name, cpu_hold, bus.in_ready, !ok);
      end
      if (ok) begin
         checks++;
         if (prog_len !== 5'(plen)) begin
            failures++;
            $display("FAIL %s_prog_len got=%0d required=%0d", name, prog_len, plen);
         end
      end
      checks++;
      if (wq.size() != wexp.size()) begin
         failures++;
         $display("FAIL %s_write_count got=%0d required=%0d", name, wq.size(), wexp.size());
      end else begin
         for (int i = 0; i < wexp.size(); i++) begin
            checks++;
            if (wq[i] !== wexp[i]) begin
               failures++;
               $display("FAIL %s_write%0d got addr=%h data=%h required addr=%h data=%h",
                        name, i, wq[i][11:8], wq[i][7:0], wexp[i][11:8], wexp[i][7:0]);
            end
         end
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 4'h0 ||
          bus.mem_wdata !== 8'h00 || cpu_hold !== 1'b1 || load_done !== 1'b0 ||
          load_err !== 1'b0 || prog_len !== 5'd0) begin
         failures++;
         $display("FAIL %s rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b len=%0d required 0,0,0,00,1,0,0,0",
                  name, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold,
                  load_done, load_err, prog_len);
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values("reset_values");
      reset = 1'b0;
      // A byte offered without start must not be accepted
      bus.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      check_reset_values("idle_no_start");
   endtask

   task automatic test_good_frame();
      byte_q_t f;
      // checksum from the XOR rule: 03^01^12^23 = 33
      f = '{8'h03, 8'h01, 8'h12, 8'h23, 8'h33};
      run_and_check("good3", f, 0, 1'b0);
   endtask

   task automatic test_bad_csum();
      byte_q_t f;
      f = '{8'h03, 8'h01, 8'h12, 8'h23, 8'h30};
      run_and_check("bad_csum", f, 0, 1'b0);
   endtask

   task automatic test_len_bounds();
      byte_q_t f;
      f = '{8'h00, 8'h01, 8'h01};
      run_and_check("len0", f, 0, 1'b0);
      f = '{8'h11, 8'h01, 8'h01};
      run_and_check("len17", f, 0, 1'b0);
      f = '{8'h80, 8'h01, 8'h01};
      run_and_check("len128", f, 0, 1'b0);
      f = make_frame(16, 0);
      run_and_check("len16", f, 0, 1'b0);
   endtask

   task automatic test_rsvd_opcode();
      byte_q_t f;
      f = '{8'h02, 8'h01, 8'hC5, 8'hC6};
      run_and_check("rsvd", f, 0, 1'b0);
   endtask

   task automatic test_gaps_midstart();
      byte_q_t f;
      f = '{8'h03, 8'h01, 8'h12, 8'h23, 8'h33};
      run_and_check("gaps3", f, 50, 1'b1);
      for (int k = 0; k < 6; k++) begin
         f = make_frame($urandom_range(1, 16), $urandom_range(0, 2));
         run_and_check($sformatf("rand%0d", k), f, 50, 1'b1);
      end
   endtask

   task automatic test_mid_reset();
      byte_q_t f;
      int      nw;
      @(negedge clk);
      wq.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      f = '{8'h03, 8'h01, 8'h12};
      send_frame(f, 0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("mid_reset");
      reset = 1'b0;
      nw = wq.size();
      checks++;
      if (nw != 2) begin
         failures++;
         $display("FAIL mid_reset_writes got=%0d required=2", nw);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h23;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      check_reset_values("post_reset_idle");
      checks++;
      if (wq.size() != nw) begin
         failures++;
         $display("FAIL post_reset_writes got=%0d required=%0d", wq.size(), nw);
      end
      f = '{8'h03, 8'h01, 8'h12, 8'h23, 8'h33};
      run_and_check("after_reset", f, 0, 1'b0);
      f = make_frame(5, 0);
      run_and_check("reload_from_done", f, 20, 1'b0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_len_bounds();
      test_rsvd_opcode();
      test_gaps_midstart();
      test_mid_reset();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
